// File: rtl/half_adder_tb_pkg.sv
// Shared types and helpers for the half-adder stimulus/checker block.
//   state_t      : sequencer states
//   NUM_VECTORS  : number of operand vectors in one sweep
//   DIN_W/DOUT_W : operand and result bus widths
//   ha_expected  : reference result word {s, c, b, a} for an operand pair
package half_adder_tb_pkg;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned DIN_W       = 2;
    localparam int unsigned DOUT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    // ab[0] = a, ab[1] = b
    function automatic logic [DOUT_W-1:0] ha_expected(input logic [DIN_W-1:0] ab);
        return {ab[0] ^ ab[1], ab[0] & ab[1], ab[1], ab[0]};
    endfunction

endpackage

// File: rtl/half_adder_resp_checker.sv
// Response compare and saturating result counters.
//   clk, rst_n       : clock, asynchronous active-low reset
//   clear            : zero both counters (run start)
//   check_en         : compare resp against the expected word for vec
//   timeout_evt      : vector lost; counts as checked and as an error
//   spurious_evt     : unexpected valid_out; counts as an error
//   vec, resp        : current operand vector and latched response
//   vec_count        : vectors checked (saturating)
//   err_count        : mismatches + timeouts + spurious (saturating)
//   err_count_next   : value err_count takes at the next edge
module half_adder_resp_checker
    import half_adder_tb_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              check_en,
    input  logic              timeout_evt,
    input  logic              spurious_evt,
    input  logic [DIN_W-1:0]  vec,
    input  logic [DOUT_W-1:0] resp,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  err_count_next
);

    logic             mismatch;
    logic [1:0]       err_inc;
    logic [CNT_W-1:0] vec_count_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                  input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        mismatch = check_en && (resp != ha_expected(vec));
        // A spurious strobe can coincide with a CHECK mismatch, so up to two errors per cycle
        err_inc  = {1'b0, mismatch} + {1'b0, timeout_evt} + {1'b0, spurious_evt};
        vec_count_next = clear ? '0 : sat_add(vec_count, {1'b0, check_en | timeout_evt});
        err_count_next = clear ? '0 : sat_add(err_count, err_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count <= '0;
            err_count <= '0;
        end else begin
            vec_count <= vec_count_next;
            err_count <= err_count_next;
        end
    end

endmodule

// File: rtl/half_adder_stim_checker.sv
// Initiator and checker for the half-adder DUT wrapper.
// On start, sweeps operand vectors 0..3 NUM_PASSES times: one-cycle valid_in
// pulse per vector, waits for valid_out (bounded by TIMEOUT_CYCLES), checks the
// returned {s,c,b,a} word and reports counters plus pass/done.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : run request, ignored while busy
//   data_bus_in  : operands to DUT (bit0 = a, bit1 = b)
//   valid_in     : operand strobe
//   data_bus_out : wrapper result {s, c, b, a}
//   valid_out    : wrapper result strobe
//   busy         : run in progress (through the DONE cycle)
//   done         : one-cycle end-of-run pulse
//   pass         : err_count was zero at end of run
//   vec_count    : vectors checked this run (saturating)
//   err_count    : errors this run (saturating)
//   timeout_err  : sticky, any vector timed out this run
module half_adder_stim_checker
    import half_adder_tb_pkg::*;
#(
    parameter int unsigned NUM_PASSES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [DIN_W-1:0]  data_bus_in,
    output logic              valid_in,
    input  logic [DOUT_W-1:0] data_bus_out,
    input  logic              valid_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              timeout_err
);

    localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic [DIN_W-1:0]    idx_q, idx_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DOUT_W-1:0]   resp_q;

    logic                clear;
    logic                check_en;
    logic                timeout_evt;
    logic                spurious_evt;
    logic                latch_resp;
    logic                advance;
    logic [CNT_W-1:0]    err_count_next;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pass_cnt_d   = pass_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        clear        = 1'b0;
        check_en     = 1'b0;
        timeout_evt  = 1'b0;
        spurious_evt = 1'b0;
        latch_resp   = 1'b0;
        advance      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    idx_d      = '0;
                    pass_cnt_d = '0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                spurious_evt = valid_out;
                wait_cnt_d   = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                // valid_out takes priority over a timeout expiring in the same cycle
                if (valid_out) begin
                    latch_resp = 1'b1;
                    state_d    = CHECK;
                end else if (32'(wait_cnt_q) == TIMEOUT_CYCLES - 1) begin
                    timeout_evt = 1'b1;
                    advance     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                check_en     = 1'b1;
                spurious_evt = valid_out;
                advance      = 1'b1;
            end
            DONE: begin
                spurious_evt = valid_out;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q != DIN_W'(NUM_VECTORS - 1)) begin
                idx_d   = idx_q + 1'b1;
                state_d = DRIVE;
            end else if (32'(pass_cnt_q) + 1 < NUM_PASSES) begin
                idx_d      = '0;
                pass_cnt_d = pass_cnt_q + 1'b1;
                state_d    = DRIVE;
            end else begin
                state_d = DONE;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pass_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            resp_q      <= '0;
            data_bus_in <= '0;
            valid_in    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            if (latch_resp) begin
                resp_q <= data_bus_out;
            end
            if (state_d == DRIVE) begin
                data_bus_in <= idx_d;
            end
            valid_in <= (state_d == DRIVE);
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            // Uses the next error count so a failure in the final CHECK/timeout is included
            if (clear) begin
                pass <= 1'b0;
            end else if (state_d == DONE) begin
                pass <= (err_count_next == '0);
            end
            if (clear) begin
                timeout_err <= 1'b0;
            end else if (timeout_evt) begin
                timeout_err <= 1'b1;
            end
        end
    end

    half_adder_resp_checker #(
        .CNT_W (CNT_W)
    ) u_resp_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .check_en       (check_en),
        .timeout_evt    (timeout_evt),
        .spurious_evt   (spurious_evt),
        .vec            (idx_q),
        .resp           (resp_q),
        .vec_count      (vec_count),
        .err_count      (err_count),
        .err_count_next (err_count_next)
    );

endmodule

// File: tb/tb_half_adder_stim_checker.sv
// Self-checking bench: three checker instances (1 pass; 3 passes; 3 passes with
// 3-bit counters and minimum timeout) run side by side against a behavioural
// wrapper model with per-vector latency, corruption, drop and extra-strobe plans.
module tb_half_adder_stim_checker;

    localparam int NI   = 3;
    localparam int NP0  = 1;
    localparam int NP1  = 3;
    localparam int NP2  = 3;
    localparam int TO0  = 8;
    localparam int TO1  = 8;
    localparam int TO2  = 2;
    localparam int MAXS = 12;
    localparam int RING = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dbi    [NI];
    logic       vin    [NI];
    logic [3:0] dbo    [NI];
    logic       vout   [NI];
    logic       busy_w [NI];
    logic       done_w [NI];
    logic       pass_w [NI];
    logic       tmo_w  [NI];
    logic [7:0] vc0, ec0, vc1, ec1;
    logic [2:0] vc2, ec2;

    int         lat   [NI][MAXS];
    logic [3:0] msk   [NI][MAXS];
    bit         extra [NI][MAXS];
    bit         sv    [NI][RING];
    logic [3:0] sd    [NI][RING];
    int         slot     [NI];
    int         done_cyc [NI];
    int         done_n   [NI];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    half_adder_stim_checker #(.NUM_PASSES(NP0), .TIMEOUT_CYCLES(TO0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .data_bus_in(dbi[0]), .valid_in(vin[0]), .data_bus_out(dbo[0]), .valid_out(vout[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .vec_count(vc0), .err_count(ec0), .timeout_err(tmo_w[0]));

    half_adder_stim_checker #(.NUM_PASSES(NP1), .TIMEOUT_CYCLES(TO1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .data_bus_in(dbi[1]), .valid_in(vin[1]), .data_bus_out(dbo[1]), .valid_out(vout[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .vec_count(vc1), .err_count(ec1), .timeout_err(tmo_w[1]));

    half_adder_stim_checker #(.NUM_PASSES(NP2), .TIMEOUT_CYCLES(TO2), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .data_bus_in(dbi[2]), .valid_in(vin[2]), .data_bus_out(dbo[2]), .valid_out(vout[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .vec_count(vc2), .err_count(ec2), .timeout_err(tmo_w[2]));

    function automatic int np_of(input int i);
        case (i)
            0:       return NP0;
            1:       return NP1;
            default: return NP2;
        endcase
    endfunction

    function automatic int to_of(input int i);
        case (i)
            0:       return TO0;
            1:       return TO1;
            default: return TO2;
        endcase
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 2) ? 7 : 255;
    endfunction

    function automatic int vc_of(input int i);
        case (i)
            0:       return 32'(vc0);
            1:       return 32'(vc1);
            default: return 32'(vc2);
        endcase
    endfunction

    function automatic int ec_of(input int i);
        case (i)
            0:       return 32'(ec0);
            1:       return 32'(ec1);
            default: return 32'(ec2);
        endcase
    endfunction

    function automatic int min2(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // Half-adder result from arithmetic: s = (a+b) mod 2, c = (a+b) div 2
    function automatic logic [3:0] ref_word(input int v);
        int a, b;
        a = v % 2;
        b = v / 2;
        return 4'((a + b) % 2 * 8 + (a + b) / 2 * 4 + b * 2 + a);
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural wrapper plus done monitor, stepped once per cycle at #1 after the edge
    initial begin
        int s, l;
        for (int i = 0; i < NI; i++) begin
            vout[i] = 1'b0;
            dbo[i]  = '0;
            slot[i] = 0;
            done_cyc[i] = -1;
            done_n[i]   = 0;
            for (int r = 0; r < RING; r++) sv[i][r] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    for (int r = 0; r < RING; r++) sv[i][r] = 1'b0;
                    vout[i] = 1'b0;
                end else begin
                    if (vin[i]) begin
                        s = slot[i];
                        if (s < 4 * np_of(i)) begin
                            check_val($sformatf("din%0d_s%0d", i, s), 32'(dbi[i]), s % 4);
                            l = lat[i][s];
                            if (l > 0) begin
                                sv[i][(cyc + l) % RING] = 1'b1;
                                sd[i][(cyc + l) % RING] = ref_word(s % 4) ^ msk[i][s];
                                if (extra[i][s]) begin
                                    sv[i][(cyc + l + 2) % RING] = 1'b1;
                                    sd[i][(cyc + l + 2) % RING] = 4'($urandom_range(0, 15));
                                end
                            end
                        end
                        slot[i]++;
                    end
                    vout[i] = sv[i][cyc % RING];
                    dbo[i]  = sv[i][cyc % RING] ? sd[i][cyc % RING] : 4'($urandom_range(0, 15));
                    sv[i][cyc % RING] = 1'b0;
                end
                if (done_w[i]) begin
                    done_n[i]++;
                    if (done_cyc[i] < 0) done_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s_ctl%0d", tag, i),
                      32'({busy_w[i], done_w[i], pass_w[i], vin[i], tmo_w[i], dbi[i]}), 0);
            check_val($sformatf("%s_vc%0d", tag, i), vc_of(i), 0);
            check_val($sformatf("%s_ec%0d", tag, i), ec_of(i), 0);
        end
    endtask

    // mode 0 ideal, 1 corrupt bit2 on vector 3, 2 drop vector 1,
    // 3 extra strobe after vector 0 plus start in DONE cycle, 4 random
    task automatic run_one(input int mode);
        int sum_c [NI];
        int errs  [NI];
        bit drops [NI];
        int n, r, c0, min_sum, stray_at, waited;
        bit all_done;
        min_sum = 1 << 20;
        for (int i = 0; i < NI; i++) begin
            n = 4 * np_of(i);
            sum_c[i] = 0;
            errs[i]  = 0;
            drops[i] = 1'b0;
            for (int s = 0; s < MAXS; s++) begin
                lat[i][s]   = 1;
                msk[i][s]   = '0;
                extra[i][s] = 1'b0;
            end
            for (int s = 0; s < n; s++) begin
                case (mode)
                    1: if (s == 3) msk[i][s] = 4'b0100;
                    2: if (s == 1) lat[i][s] = 0;
                    3: if (s == 0) extra[i][s] = 1'b1;
                    4: begin
                        r = $urandom_range(0, 99);
                        if (r < 10)      lat[i][s] = 0;
                        else if (r < 55) lat[i][s] = 1;
                        else             lat[i][s] = $urandom_range(2, to_of(i));
                        if (lat[i][s] > 0 && $urandom_range(0, 99) < 15)
                            msk[i][s] = 4'($urandom_range(1, 15));
                        if (lat[i][s] > 0 && s < n - 1 && $urandom_range(0, 99) < 15)
                            extra[i][s] = 1'b1;
                    end
                    default: ;
                endcase
                // Per vector: DRIVE + WAIT cycles (+ CHECK when answered)
                if (lat[i][s] == 0) begin
                    sum_c[i] += 1 + to_of(i);
                    errs[i]++;
                    drops[i] = 1'b1;
                end else begin
                    sum_c[i] += 2 + lat[i][s];
                    if (msk[i][s] != 0) errs[i]++;
                    if (extra[i][s]) errs[i]++;
                end
            end
            min_sum = min2(min_sum, sum_c[i]);
            slot[i] = 0;
            done_cyc[i] = -1;
            done_n[i] = 0;
        end

        @(posedge clk); #2;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #2;
        start = 1'b0;

        if (mode == 3 || (mode == 4 && $urandom_range(0, 1) == 1)) begin
            stray_at = (mode == 3) ? c0 + min_sum + 1 : $urandom_range(c0 + 2, c0 + min_sum + 1);
            while (cyc < stray_at) begin @(posedge clk); #2; end
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end

        waited = 0;
        all_done = 1'b0;
        while (!all_done && waited < 400) begin
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) if (done_cyc[i] < 0) all_done = 1'b0;
            if (!all_done) begin
                @(posedge clk); #2;
                waited++;
            end
        end
        repeat (3) begin @(posedge clk); #2; end

        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("m%0d_done_seen%0d", mode, i), 32'(done_cyc[i] >= 0), 1);
            check_val($sformatf("m%0d_len%0d", mode, i), done_cyc[i] - c0 + 1, sum_c[i] + 2);
            check_val($sformatf("m%0d_ndone%0d", mode, i), done_n[i], 1);
            check_val($sformatf("m%0d_nvalid_in%0d", mode, i), slot[i], 4 * np_of(i));
            check_val($sformatf("m%0d_vec%0d", mode, i), vc_of(i), min2(4 * np_of(i), cmax_of(i)));
            check_val($sformatf("m%0d_err%0d", mode, i), ec_of(i), min2(errs[i], cmax_of(i)));
            check_val($sformatf("m%0d_pass%0d", mode, i), 32'(pass_w[i]), 32'(errs[i] == 0));
            check_val($sformatf("m%0d_tmo%0d", mode, i), 32'(tmo_w[i]), 32'(drops[i]));
            check_val($sformatf("m%0d_busy%0d", mode, i), 32'(busy_w[i]), 0);
        end
    endtask

    task automatic reset_mid_run();
        int waited, nd;
        for (int i = 0; i < NI; i++) begin
            for (int s = 0; s < MAXS; s++) begin
                lat[i][s]   = (s == 2) ? to_of(i) : 1;
                msk[i][s]   = '0;
                extra[i][s] = 1'b0;
            end
            slot[i] = 0;
            done_cyc[i] = -1;
            done_n[i] = 0;
        end
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        waited = 0;
        while (!(vin[0] && dbi[0] == 2'd2) && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        check_val("rst_reach_v2", 32'(vin[0] && dbi[0] == 2'd2), 1);
        @(posedge clk); #3;
        check_val("rst_in_wait_busy", 32'(busy_w[0]), 1);
        nd = done_n[0];
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        repeat (4) begin @(posedge clk); #2; end
        check_val("rst_no_done", done_n[0] - nd, 0);
        check_outputs_zero("rst_hold");
        rst_n = 1'b1;
        run_one(0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        run_one(0);
        run_one(1);
        run_one(2);
        run_one(3);
        for (int k = 0; k < 20; k++) run_one(4);
        reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
        $fatal(1, "bench did not complete");
    end

endmodule
